// File: rtl/tomasulo_rob.sv
// Reorder buffer for the Tomasulo core: in-order alloc/retire,
// out-of-order CDB writeback, flush on mispredicted branch retire.
module tomasulo_rob #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk1,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [REG_AW-1:0] alloc_rd,
  input  logic              alloc_is_branch,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_mispredict,
  input  logic [TAG_W-1:0]  lk_tag,
  output logic              lk_ready,
  output logic [DATA_W-1:0] lk_data,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_AW-1:0] commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic              commit_is_branch,
  output logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  done;
  logic [DEPTH-1:0]  is_br;
  logic [DEPTH-1:0]  mispred;
  logic [REG_AW-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    cnt;

  logic do_alloc;
  logic do_wb;
  logic do_commit;
  logic do_flush;
  logic fwd;

  always_comb begin
    do_commit   = valid[head] & done[head];
    do_flush    = do_commit & is_br[head] & mispred[head];
    full        = (cnt == (TAG_W+1)'(DEPTH));
    empty       = (cnt == '0);
    // a pending mispredict at head blocks issue until the flush lands
    alloc_ready = !full && !(valid[head] && done[head] && mispred[head]);
    do_alloc    = alloc_valid && alloc_ready;
    do_wb       = cdb_valid && valid[cdb_tag] && !do_flush
                  && !(do_alloc && (cdb_tag == tail));
    fwd         = cdb_valid && (cdb_tag == lk_tag) && valid[lk_tag];
    lk_ready    = fwd || (valid[lk_tag] && done[lk_tag]);
    lk_data     = fwd ? cdb_data : data_q[lk_tag];
    alloc_tag   = tail;
    count       = cnt;
  end

  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      valid            <= '0;
      done             <= '0;
      is_br            <= '0;
      mispred          <= '0;
      head             <= '0;
      tail             <= '0;
      cnt              <= '0;
      commit_valid     <= 1'b0;
      commit_tag       <= '0;
      commit_rd        <= '0;
      commit_data      <= '0;
      commit_is_branch <= 1'b0;
      flush            <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      commit_valid <= do_commit;
      flush        <= do_flush;
      if (do_commit) begin
        commit_tag       <= head;
        commit_rd        <= rd_q[head];
        commit_data      <= data_q[head];
        commit_is_branch <= is_br[head];
      end
      if (do_flush) begin
        valid   <= '0;
        done    <= '0;
        mispred <= '0;
        head    <= '0;
        tail    <= '0;
        cnt     <= '0;
      end else begin
        if (do_wb) begin
          done[cdb_tag]    <= 1'b1;
          data_q[cdb_tag]  <= cdb_data;
          mispred[cdb_tag] <= cdb_mispredict & is_br[cdb_tag];
        end
        if (do_commit) begin
          valid[head]   <= 1'b0;
          done[head]    <= 1'b0;
          mispred[head] <= 1'b0;
          head          <= head + 1'b1;
        end
        if (do_alloc) begin
          valid[tail]   <= 1'b1;
          done[tail]    <= 1'b0;
          mispred[tail] <= 1'b0;
          rd_q[tail]    <= alloc_rd;
          is_br[tail]   <= alloc_is_branch;
          tail          <= tail + 1'b1;
        end
        cnt <= cnt + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_commit);
      end
    end
  end

endmodule

// File: tb/tb_tomasulo_rob.sv
// Directed bench for tomasulo_rob: fill/drain, wrap, out-of-order
// completion, mispredict flush, lookup bypass and async reset.
module tb_tomasulo_rob;

  logic        clk1 = 1'b0;
  logic        reset = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [3:0]  alloc_rd = '0;
  logic        alloc_is_branch = 1'b0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic        cdb_mispredict = 1'b0;
  logic [2:0]  lk_tag = '0;
  logic        lk_ready;
  logic [15:0] lk_data;
  logic        commit_valid;
  logic [2:0]  commit_tag;
  logic [3:0]  commit_rd;
  logic [15:0] commit_data;
  logic        commit_is_branch;
  logic        flush;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int n_chk = 0;
  int n_pass = 0;

  tomasulo_rob dut (
    .clk1(clk1), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_is_branch(alloc_is_branch),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_mispredict(cdb_mispredict),
    .lk_tag(lk_tag), .lk_ready(lk_ready), .lk_data(lk_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_is_branch(commit_is_branch), .flush(flush),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk1);
    #1;
  endtask

  task automatic do_reset;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] rd, input logic br);
    alloc_valid = 1'b1;
    alloc_rd = rd;
    alloc_is_branch = br;
    tick();
    alloc_valid = 1'b0;
    alloc_is_branch = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [15:0] d,
                     input logic mp);
    cdb_valid = 1'b1;
    cdb_tag = t;
    cdb_data = d;
    cdb_mispredict = mp;
    tick();
    cdb_valid = 1'b0;
    cdb_mispredict = 1'b0;
  endtask

  initial begin
    // reset state
    #3;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_cv", commit_valid, 0);
    chk("rst_flush", flush, 0);
    @(negedge clk1);
    reset = 1'b0;

    // fill and drain
    for (int i = 0; i < 8; i++) begin
      chk("fill_tag", alloc_tag, i);
      alloc(4'(i + 1), 1'b0);
    end
    chk("fill_full", full, 1);
    chk("fill_ready", alloc_ready, 0);
    chk("fill_count", count, 8);
    for (int i = 7; i >= 0; i--) begin
      cdb(3'(i), 16'h0100 + 16'(i), 1'b0);
      chk("drain_nocommit", commit_valid, 0);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("drain_cv", commit_valid, 1);
      chk("drain_tag", commit_tag, i);
      chk("drain_rd", commit_rd, i + 1);
      chk("drain_data", commit_data, 32'h100 + i);
    end
    chk("drain_empty", empty, 1);
    tick();
    chk("drain_idle", commit_valid, 0);

    // wrap-around
    do_reset();
    for (int i = 0; i < 6; i++) alloc(4'(i), 1'b0);
    for (int i = 0; i < 6; i++) cdb(3'(i), 16'(i), 1'b0);
    tick();
    tick();
    chk("wrap_drained", count, 0);
    chk("wrap_tag0", alloc_tag, 6); alloc(4'd1, 1'b0);
    chk("wrap_tag1", alloc_tag, 7); alloc(4'd2, 1'b0);
    chk("wrap_tag2", alloc_tag, 0); alloc(4'd3, 1'b0);
    chk("wrap_tag3", alloc_tag, 1); alloc(4'd4, 1'b0);
    chk("wrap_count", count, 4);

    // out-of-order completion
    do_reset();
    for (int i = 0; i < 3; i++) alloc(4'(i + 5), 1'b0);
    cdb(3'd2, 16'h0202, 1'b0);
    chk("ooo_wait0", commit_valid, 0);
    cdb(3'd1, 16'h0201, 1'b0);
    chk("ooo_wait1", commit_valid, 0);
    tick();
    chk("ooo_wait2", commit_valid, 0);
    tick();
    chk("ooo_wait3", commit_valid, 0);
    cdb(3'd0, 16'h0200, 1'b0);
    chk("ooo_wait4", commit_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ooo_cv", commit_valid, 1);
      chk("ooo_tag", commit_tag, i);
      chk("ooo_data", commit_data, 32'h200 + i);
    end
    tick();
    chk("ooo_done", commit_valid, 0);
    chk("ooo_empty", empty, 1);

    // mispredict flush
    do_reset();
    alloc(4'd1, 1'b0);
    alloc(4'd0, 1'b1);
    alloc(4'd3, 1'b0);
    alloc(4'd4, 1'b0);
    cdb(3'd0, 16'h0010, 1'b0);
    cdb(3'd1, 16'h0001, 1'b1);
    chk("mp_c0_cv", commit_valid, 1);
    chk("mp_c0_tag", commit_tag, 0);
    chk("mp_c0_flush", flush, 0);
    chk("mp_block", alloc_ready, 0);
    cdb(3'd3, 16'h0033, 1'b0);
    chk("mp_c1_cv", commit_valid, 1);
    chk("mp_c1_tag", commit_tag, 1);
    chk("mp_c1_br", commit_is_branch, 1);
    chk("mp_flush", flush, 1);
    chk("mp_count", count, 0);
    chk("mp_atag", alloc_tag, 0);
    chk("mp_empty", empty, 1);
    lk_tag = 3'd3;
    #1;
    chk("mp_lk3", lk_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mp_nocommit", commit_valid, 0);
      chk("mp_noflush", flush, 0);
    end

    // mispredict on a non-branch entry
    do_reset();
    alloc(4'd2, 1'b0);
    alloc(4'd3, 1'b0);
    cdb(3'd0, 16'h0044, 1'b1);
    chk("nb_ready", alloc_ready, 1);
    tick();
    chk("nb_cv", commit_valid, 1);
    chk("nb_flush", flush, 0);
    chk("nb_count", count, 1);

    // lookup bypass and corners
    do_reset();
    for (int i = 0; i < 5; i++) alloc(4'(i + 8), 1'b0);
    lk_tag = 3'd3;
    cdb_valid = 1'b1;
    cdb_tag = 3'd3;
    cdb_data = 16'hBEEF;
    #1;
    chk("byp_ready", lk_ready, 1);
    chk("byp_data", lk_data, 16'hBEEF);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("lk_held_rdy", lk_ready, 1);
    chk("lk_held_data", lk_data, 16'hBEEF);
    lk_tag = 3'd2;
    #1;
    chk("lk_notdone", lk_ready, 0);
    lk_tag = 3'd6;
    cdb_valid = 1'b1;
    cdb_tag = 3'd6;
    cdb_data = 16'h1234;
    #1;
    chk("unalloc_fwd", lk_ready, 0);
    tick();
    cdb_valid = 1'b0;
    #1;
    chk("unalloc_rdy", lk_ready, 0);
    chk("unalloc_cnt", count, 5);
    cdb(3'd0, 16'h0055, 1'b0);
    tick();
    chk("pre_cv", commit_valid, 1);
    chk("pre_count", count, 4);
    alloc(4'd15, 1'b0);
    chk("pre_live", count, 5);
    chk("pre_hold", commit_data, 16'h0055);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", alloc_ready, 1);
    chk("arst_tag", alloc_tag, 0);
    chk("arst_cv", commit_valid, 0);
    chk("arst_cdata", commit_data, 0);
    chk("arst_crd", commit_rd, 0);
    chk("arst_ctag", commit_tag, 0);
    @(negedge clk1);
    reset = 1'b0;
    tick();
    chk("arst_nocommit", commit_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
